// File: rtl/bus_word_fifo.sv
// Word FIFO between the ARM parallel-bus front end and a fabric valid/ready stream,
// with a bus-readable status word. Define BUS_FIFO_STATUS_CLR_EN to clear ovf on status read.
module bus_word_fifo #(
    parameter int WIDTH      = 16,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             wr_stb,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_stb,
    output logic [15:0]      rd_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic [15:0]           rd_data_q, rd_data_d;

    logic full, empty, push, pop, overflow;

    assign full  = (count_q == CNT_FULL);
    assign empty = (count_q == '0);
    assign pop   = ~empty & out_ready;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign push     = wr_stb & (~full | pop);
    assign overflow = wr_stb & full & ~pop;

    assign out_valid = ~empty;
    assign out_data  = empty ? '0 : mem[rd_ptr_q];
    assign rd_data   = rd_data_q;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        rd_data_d = rd_data_q;

        if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        // Status snapshots the pre-edge state, before this cycle's push/pop/overflow.
        if (rd_stb) rd_data_d = {ovf_q, full, empty, 13'(count_q)};

`ifdef BUS_FIFO_STATUS_CLR_EN
        ovf_d = overflow | (ovf_q & ~rd_stb);
`else
        ovf_d = overflow | ovf_q;
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            rd_data_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            rd_data_q <= rd_data_d;
        end
    end

    // NOTE: storage is deliberately left out of reset; its contents are never visible while empty.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr_q] <= wr_data;
    end

endmodule

// File: tb/tb_bus_word_fifo.sv
// Directed testbench for bus_word_fifo; expectations follow BUS_FIFO_STATUS_CLR_EN when defined.
module tb_bus_word_fifo;

    logic        clock;
    logic        reset_n;
    logic        wr_stb;
    logic [15:0] wr_data;
    logic        rd_stb;
    logic [15:0] rd_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;

    int tests_run = 0;
    int tests_failed = 0;

    bus_word_fifo #(.WIDTH(16), .DEPTH_LOG2(4)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .wr_stb   (wr_stb),
        .wr_data  (wr_data),
        .rd_stb   (rd_stb),
        .rd_data  (rd_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Inputs change on the falling edge; outputs are sampled on the falling edge after the DUT edge.
    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic write_word(input logic [15:0] w);
        @(negedge clock);
        wr_stb  = 1'b1;
        wr_data = w;
        @(negedge clock);
        wr_stb  = 1'b0;
    endtask

    task automatic read_status(output logic [15:0] s);
        @(negedge clock);
        rd_stb = 1'b1;
        @(negedge clock);
        rd_stb = 1'b0;
        s = rd_data;
    endtask

    task automatic test_reset();
        logic [15:0] s;
        do_reset();
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_valid: got %b want 0", out_valid);
        end
        tests_run++;
        if (out_data !== 16'h0000) begin
            tests_failed++;
            $display("FAIL reset_out_data: got %h want 0000", out_data);
        end
        tests_run++;
        if (rd_data !== 16'h0000) begin
            tests_failed++;
            $display("FAIL reset_rd_data: got %h want 0000", rd_data);
        end
        read_status(s);
        tests_run++;
        if (s !== 16'h2000) begin
            tests_failed++;
            $display("FAIL reset_status: got %h want 2000", s);
        end
    endtask

    task automatic test_order();
        logic [15:0] s;
        logic [15:0] exp_words [3];
        exp_words[0] = 16'h1111;
        exp_words[1] = 16'h2222;
        exp_words[2] = 16'h3333;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) write_word(exp_words[i]);
        read_status(s);
        tests_run++;
        if (s !== 16'h0003) begin
            tests_failed++;
            $display("FAIL order_status: got %h want 0003", s);
        end
        tests_run++;
        if (out_data !== 16'h1111 || out_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL order_head_stable: got %h/%b want 1111/1", out_data, out_valid);
        end
        @(negedge clock);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (out_valid !== 1'b1 || out_data !== exp_words[i]) begin
                tests_failed++;
                $display("FAIL order_pop%0d: got %h/%b want %h/1", i, out_data, out_valid, exp_words[i]);
            end
            @(negedge clock);
        end
        out_ready = 1'b0;
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL order_empty: got %b want 0", out_valid);
        end
    endtask

    // Also covers the status-read ovf clear behaviour before the drain.
    task automatic test_full_overflow();
        logic [15:0] s;
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) write_word(16'hA000 + 16'(i));
        read_status(s);
        tests_run++;
        if (s !== 16'h4010) begin
            tests_failed++;
            $display("FAIL full_status: got %h want 4010", s);
        end
        write_word(16'hDEAD);
        read_status(s);
        tests_run++;
        if (s !== 16'hC010) begin
            tests_failed++;
            $display("FAIL ovf_status: got %h want C010", s);
        end
        read_status(s);
        tests_run++;
`ifdef BUS_FIFO_STATUS_CLR_EN
        if (s !== 16'h4010) begin
            tests_failed++;
            $display("FAIL ovf_clear: got %h want 4010", s);
        end
`else
        if (s !== 16'hC010) begin
            tests_failed++;
            $display("FAIL ovf_sticky: got %h want C010", s);
        end
`endif
        @(negedge clock);
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tests_run++;
            if (out_valid !== 1'b1 || out_data !== 16'hA000 + 16'(i)) begin
                tests_failed++;
                $display("FAIL full_drain%0d: got %h/%b want %h/1", i, out_data, out_valid, 16'hA000 + 16'(i));
            end
            @(negedge clock);
        end
        out_ready = 1'b0;
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL full_drain_empty: got %b want 0 (head %h)", out_valid, out_data);
        end
    endtask

    task automatic test_full_push_pop();
        logic [15:0] s;
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) write_word(16'hB000 + 16'(i));
        @(negedge clock);
        out_ready = 1'b1;
        wr_stb    = 1'b1;
        wr_data   = 16'hBEEF;
        tests_run++;
        if (out_data !== 16'hB000) begin
            tests_failed++;
            $display("FAIL pp_head: got %h want B000", out_data);
        end
        @(negedge clock);
        out_ready = 1'b0;
        wr_stb    = 1'b0;
        read_status(s);
        tests_run++;
        if (s !== 16'h4010) begin
            tests_failed++;
            $display("FAIL pp_status: got %h want 4010", s);
        end
        @(negedge clock);
        out_ready = 1'b1;
        for (int i = 1; i < 17; i++) begin
            tests_run++;
            if (out_valid !== 1'b1 || out_data !== ((i == 16) ? 16'hBEEF : 16'hB000 + 16'(i))) begin
                tests_failed++;
                $display("FAIL pp_drain%0d: got %h/%b want %h/1", i, out_data, out_valid,
                         (i == 16) ? 16'hBEEF : 16'hB000 + 16'(i));
            end
            @(negedge clock);
        end
        out_ready = 1'b0;
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL pp_empty: got %b want 0", out_valid);
        end
    endtask

    task automatic test_mid_reset();
        logic [15:0] s;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) write_word(16'hC000 + 16'(i));
        read_status(s);
        tests_run++;
        if (s !== 16'h0005) begin
            tests_failed++;
            $display("FAIL mid_status5: got %h want 0005", s);
        end
        #2;
        reset_n = 1'b0;
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || out_data !== 16'h0000) begin
            tests_failed++;
            $display("FAIL mid_async: got %h/%b want 0000/0", out_data, out_valid);
        end
        @(negedge clock);
        reset_n = 1'b1;
        read_status(s);
        tests_run++;
        if (s !== 16'h2000) begin
            tests_failed++;
            $display("FAIL mid_after: got %h want 2000", s);
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        wr_stb    = 1'b0;
        wr_data   = '0;
        rd_stb    = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_order();
        test_full_overflow();
        test_full_push_pop();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
